counter_monitor: RTL and testbench

//  Receive-side checker for the up/down/preload counter's qout bus. Samples the

---
 rtl/counter_mon_pkg.sv | 20 ++
 rtl/counter_step_classify.sv | 36 +++
 rtl/counter_monitor.sv | 201 ++++++++++++++++++++
 tb/tb_counter_monitor.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_mon_pkg.sv
// Shared types for the counter monitor: FSM states, step classes and default
// bus width.
package counter_mon_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    JUMP = 2'd3
  } step_t;

endpackage

// File: rtl/counter_step_classify.sv
// Classifies one observed count step (modulo 2^WIDTH) against the previous
// sample and flags a terminal-count wrap.
module counter_step_classify
  import counter_mon_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] i_prev,
  input  logic [WIDTH-1:0] i_cnt,
  input  logic             i_pl_seen,
  output step_t            o_step,
  output logic             o_wrap
);

  logic [WIDTH-1:0] w_diff;

  assign w_diff = i_cnt - i_prev;

  // A flagged preload is a jump no matter how small the distance is.
  always_comb begin
    o_step = JUMP;
    o_wrap = 1'b0;
    if (!i_pl_seen) begin
      if (w_diff == '0) begin
        o_step = HOLD;
      end else if (w_diff == WIDTH'(1)) begin
        o_step = UP;
        o_wrap = (i_prev == '1);
      end else if (w_diff == '1) begin
        o_step = DOWN;
        o_wrap = (i_prev == '0);
      end
    end
  end

endmodule

// File: rtl/counter_monitor.sv
// Observer for an up/down/preload counter: infers direction and lock from the
// sampled count and reports wraps, preload jumps and illegal jumps.
module counter_monitor
  import counter_mon_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             pl_seen,
  input  logic             clr_err,
  output logic             locked,
  output logic             dir,
  output logic             dir_chg,
  output logic             wrap,
  output logic             jump,
  output logic [WIDTH-1:0] jump_val,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int RUN_W = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

  state_t           r_state;
  state_t           w_stateNxt;
  logic [WIDTH-1:0] r_prev;
  logic [RUN_W-1:0] r_run;
  logic [RUN_W-1:0] w_runNxt;
  logic [RUN_W-1:0] w_runStep;
  logic             r_cand;
  logic             w_candNxt;
  logic             r_locked;
  logic             w_lockedNxt;
  logic             r_dir;
  logic             w_dirNxt;
  logic             r_dirChg;
  logic             w_dirChgNxt;
  logic             r_wrap;
  logic             w_wrapNxt;
  logic             r_jump;
  logic             w_jumpNxt;
  logic [WIDTH-1:0] r_jumpVal;
  logic [WIDTH-1:0] w_jumpValNxt;
  logic             r_err;
  logic             w_errNxt;
  logic [ERR_W-1:0] r_errCnt;
  step_t            w_step;
  logic             w_wrap;
  logic             w_stepUp;

  counter_step_classify #(
    .WIDTH(WIDTH)
  ) u_classify (
    .i_prev   (r_prev),
    .i_cnt    (cnt_in),
    .i_pl_seen(pl_seen),
    .o_step   (w_step),
    .o_wrap   (w_wrap)
  );

  assign w_stepUp = (w_step == UP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNxt;
    end
  end

  // Pulses default low, so a disabled cycle freezes state and emits nothing.
  always_comb begin
    w_stateNxt   = r_state;
    w_runNxt     = r_run;
    w_candNxt    = r_cand;
    w_lockedNxt  = r_locked;
    w_dirNxt     = r_dir;
    w_dirChgNxt  = 1'b0;
    w_wrapNxt    = 1'b0;
    w_jumpNxt    = 1'b0;
    w_jumpValNxt = r_jumpVal;
    w_errNxt     = 1'b0;
    w_runStep    = (w_stepUp == r_cand) ? r_run + 1'b1 : RUN_W'(1);
    if (enable) begin
      case (r_state)
        IDLE: begin
          w_stateNxt = ACQ;
        end
        ACQ: begin
          w_wrapNxt = w_wrap;
          unique case (w_step)
            UP, DOWN: begin
              w_candNxt = w_stepUp;
              w_runNxt  = w_runStep;
              if (w_runStep >= RUN_W'(LOCK_CNT)) begin
                w_stateNxt  = LOCK;
                w_lockedNxt = 1'b1;
                w_dirNxt    = w_stepUp;
                w_runNxt    = '0;
              end
            end
            HOLD: begin
            end
            JUMP: begin
              w_runNxt = '0;
              if (pl_seen) begin
                w_jumpNxt    = 1'b1;
                w_jumpValNxt = cnt_in;
              end else begin
                w_errNxt = 1'b1;
              end
            end
          endcase
        end
        LOCK: begin
          w_wrapNxt = w_wrap;
          unique case (w_step)
            UP, DOWN: begin
              if (w_stepUp != r_dir) begin
                w_dirNxt    = w_stepUp;
                w_candNxt   = w_stepUp;
                w_dirChgNxt = 1'b1;
              end
            end
            HOLD: begin
            end
            JUMP: begin
              if (pl_seen) begin
                w_jumpNxt    = 1'b1;
                w_jumpValNxt = cnt_in;
              end else begin
                w_errNxt    = 1'b1;
                w_lockedNxt = 1'b0;
                w_runNxt    = '0;
                w_stateNxt  = ACQ;
              end
            end
          endcase
        end
        default: begin
          w_stateNxt  = IDLE;
          w_lockedNxt = 1'b0;
          w_runNxt    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prev    <= '0;
      r_run     <= '0;
      r_cand    <= 1'b0;
      r_locked  <= 1'b0;
      r_dir     <= 1'b0;
      r_dirChg  <= 1'b0;
      r_wrap    <= 1'b0;
      r_jump    <= 1'b0;
      r_jumpVal <= '0;
      r_err     <= 1'b0;
    end else begin
      if (enable) begin
        r_prev <= cnt_in;
      end
      r_run     <= w_runNxt;
      r_cand    <= w_candNxt;
      r_locked  <= w_lockedNxt;
      r_dir     <= w_dirNxt;
      r_dirChg  <= w_dirChgNxt;
      r_wrap    <= w_wrapNxt;
      r_jump    <= w_jumpNxt;
      r_jumpVal <= w_jumpValNxt;
      r_err     <= w_errNxt;
    end
  end

  // Clear has priority over a same-cycle increment and ignores enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_errCnt <= '0;
    end else if (clr_err) begin
      r_errCnt <= '0;
    end else if (w_errNxt && (r_errCnt != '1)) begin
      r_errCnt <= r_errCnt + 1'b1;
    end
  end

  assign locked   = r_locked;
  assign dir      = r_dir;
  assign dir_chg  = r_dirChg;
  assign wrap     = r_wrap;
  assign jump     = r_jump;
  assign jump_val = r_jumpVal;
  assign err      = r_err;
  assign err_cnt  = r_errCnt;

endmodule

// File: tb/tb_counter_monitor.sv
// Directed scoreboard bench for counter_monitor: each driven sample queues its
// hand-computed response, and a monitor compares it one edge later.
module tb_counter_monitor;

  localparam int WIDTH    = 8;
  localparam int LOCK_CNT = 2;
  localparam int ERR_W    = 8;

  localparam logic [3:0] P_NONE = 4'b0000;
  localparam logic [3:0] P_DCHG = 4'b1000;
  localparam logic [3:0] P_WRAP = 4'b0100;
  localparam logic [3:0] P_JUMP = 4'b0010;
  localparam logic [3:0] P_ERR  = 4'b0001;

  typedef struct packed {
    logic             locked;
    logic             dir;
    logic             dirChg;
    logic             wrap;
    logic             jump;
    logic [WIDTH-1:0] jumpVal;
    logic             err;
    logic [ERR_W-1:0] errCnt;
  } expect_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [WIDTH-1:0] cnt_in;
  logic             pl_seen;
  logic             clr_err;
  logic             locked;
  logic             dir;
  logic             dir_chg;
  logic             wrap;
  logic             jump;
  logic [WIDTH-1:0] jump_val;
  logic             err;
  logic [ERR_W-1:0] err_cnt;

  expect_t          expQ[$];
  string            nameQ[$];
  int               checkCount = 0;
  int               errorCount = 0;
  logic             expLocked;
  logic             expDir;
  logic [WIDTH-1:0] expJumpVal;
  logic [ERR_W-1:0] expErrCnt;

  always #5 clk = ~clk;

  counter_monitor #(
    .WIDTH   (WIDTH),
    .LOCK_CNT(LOCK_CNT),
    .ERR_W   (ERR_W)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .cnt_in  (cnt_in),
    .pl_seen (pl_seen),
    .clr_err (clr_err),
    .locked  (locked),
    .dir     (dir),
    .dir_chg (dir_chg),
    .wrap    (wrap),
    .jump    (jump),
    .jump_val(jump_val),
    .err     (err),
    .err_cnt (err_cnt)
  );

  task automatic checkOutput(input string name, input expect_t req);
    expect_t got;
    got.locked  = locked;
    got.dir     = dir;
    got.dirChg  = dir_chg;
    got.wrap    = wrap;
    got.jump    = jump;
    got.jumpVal = jump_val;
    got.err     = err;
    got.errCnt  = err_cnt;
    checkCount++;
    if (got !== req) begin
      errorCount++;
      $display("[TB] FAIL %s: got lock=%0b dir=%0b dchg=%0b wrap=%0b jump=%0b jv=%0d err=%0b ecnt=%0d, required lock=%0b dir=%0b dchg=%0b wrap=%0b jump=%0b jv=%0d err=%0b ecnt=%0d",
               name, got.locked, got.dir, got.dirChg, got.wrap, got.jump, got.jumpVal, got.err, got.errCnt,
               req.locked, req.dir, req.dirChg, req.wrap, req.jump, req.jumpVal, req.err, req.errCnt);
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] cnt, input logic pl, input logic en,
                               input logic clr, input logic [3:0] pulses, input string name);
    expect_t e;
    @(negedge clk);
    cnt_in  = cnt;
    pl_seen = pl;
    enable  = en;
    clr_err = clr;
    e.locked  = expLocked;
    e.dir     = expDir;
    e.dirChg  = pulses[3];
    e.wrap    = pulses[2];
    e.jump    = pulses[1];
    e.jumpVal = expJumpVal;
    e.err     = pulses[0];
    e.errCnt  = expErrCnt;
    expQ.push_back(e);
    nameQ.push_back(name);
  endtask

  task automatic step(input logic [WIDTH-1:0] cnt, input logic [3:0] pulses, input string name);
    applyStimulus(cnt, 1'b0, 1'b1, 1'b0, pulses, name);
  endtask

  // Monitor: one response per driven sample, visible just after the edge.
  initial begin
    expect_t e;
    string   n;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        n = nameQ.pop_front();
        checkOutput(n, e);
      end
    end
  end

  initial begin
    reset      = 1'b0;
    enable     = 1'b0;
    cnt_in     = '0;
    pl_seen    = 1'b0;
    clr_err    = 1'b0;
    expLocked  = 1'b0;
    expDir     = 1'b0;
    expJumpVal = '0;
    expErrCnt  = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_state", '0);
    @(negedge clk);
    reset = 1'b1;

    $display("[TB] count up from 0, lock after third sample");
    for (int k = 0; k < 30; k++) begin
      if (k == 2) begin
        expLocked = 1'b1;
        expDir    = 1'b1;
      end
      step(8'(k), P_NONE, "t1_count_up");
    end

    $display("[TB] legal preload while locked");
    step(8'd30, P_NONE, "t3_locked_30");
    expJumpVal = 8'd50;
    applyStimulus(8'd50, 1'b1, 1'b1, 1'b0, P_JUMP, "t3_preload_50");
    step(8'd51, P_NONE, "t3_after_51");
    step(8'd52, P_NONE, "t3_after_52");

    $display("[TB] up-count wrap");
    expJumpVal = 8'd252;
    applyStimulus(8'd252, 1'b1, 1'b1, 1'b0, P_JUMP, "t2_preload_252");
    step(8'd253, P_NONE, "t2_253");
    step(8'd254, P_NONE, "t2_254");
    step(8'd255, P_NONE, "t2_255");
    step(8'd0,   P_WRAP, "t2_wrap_up");
    step(8'd1,   P_NONE, "t2_after_wrap");

    $display("[TB] direction reversal and down wrap");
    expJumpVal = 8'd80;
    applyStimulus(8'd80, 1'b1, 1'b1, 1'b0, P_JUMP, "t4_preload_80");
    expDir = 1'b0;
    step(8'd79, P_DCHG, "t4_dir_chg");
    step(8'd78, P_NONE, "t4_down_78");
    step(8'd77, P_NONE, "t4_down_77");
    expJumpVal = 8'd2;
    applyStimulus(8'd2, 1'b1, 1'b1, 1'b0, P_JUMP, "t4_preload_2");
    step(8'd1,   P_NONE, "t4_down_1");
    step(8'd0,   P_NONE, "t4_down_0");
    step(8'd255, P_WRAP, "t4_wrap_down");
    step(8'd254, P_NONE, "t4_down_254");

    $display("[TB] illegal jump, relock, error saturation and clear");
    expJumpVal = 8'd10;
    applyStimulus(8'd10, 1'b1, 1'b1, 1'b0, P_JUMP, "t5_preload_10");
    expLocked = 1'b0;
    expErrCnt = 8'd1;
    step(8'd90, P_ERR,  "t5_illegal_jump");
    step(8'd91, P_NONE, "t5_acq_91");
    expLocked = 1'b1;
    expDir    = 1'b1;
    step(8'd92, P_NONE, "t5_relock");
    expLocked = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (expErrCnt != 8'hFF) expErrCnt = expErrCnt + 8'd1;
      step((i % 2 == 0) ? 8'd200 : 8'd92, P_ERR, "t5_err_burst");
    end
    applyStimulus(8'd5, 1'b0, 1'b0, 1'b0, P_NONE, "t5_disabled_hold");
    expErrCnt = 8'd0;
    applyStimulus(8'd5, 1'b0, 1'b0, 1'b1, P_NONE, "t5_clr_while_disabled");
    step(8'd92, P_NONE, "t5_hold_after_freeze");
    applyStimulus(8'd150, 1'b0, 1'b1, 1'b1, P_ERR, "t5_clr_beats_inc");
    step(8'd151, P_NONE, "t5_acq_151");
    expLocked = 1'b1;
    step(8'd152, P_NONE, "t5_relock2");
    step(8'd153, P_NONE, "t5_locked_153");

    $display("[TB] asynchronous reset mid-lock");
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    expLocked  = 1'b0;
    expDir     = 1'b0;
    expJumpVal = '0;
    expErrCnt  = '0;
    checkOutput("t6_async_reset", '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    cnt_in = 8'd5;
    reset  = 1'b1;
    step(8'd5, P_NONE, "t6_first_sample");
    step(8'd6, P_NONE, "t6_acq_6");
    expLocked = 1'b1;
    expDir    = 1'b1;
    step(8'd7, P_NONE, "t6_relock");
    step(8'd8, P_NONE, "t6_locked_8");

    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
    #2;
    if (expQ.size() != 0) begin
      errorCount++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, required 0", expQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
